// File: rtl/pc_sequencer.sv
// Program-counter and fetch sequencer: run/step/halt control, commit qualification, retire count.
// Optional PC_BREAKPOINT_EN adds a single address breakpoint with resume-once semantics.
module pc_sequencer #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step,
  input  logic             halt_req,
  input  logic [31:0]      end_addr,
  input  logic [31:0]      next_addr,
`ifdef PC_BREAKPOINT_EN
  input  logic             bp_valid,
  input  logic [31:0]      bp_addr,
`endif
  output logic [31:0]      pc,
  output logic             exec_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] retired,
  output logic             misaligned
);

  typedef enum logic [1:0] {StIdle, StRun, StStep, StHalt} state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             mis_q, mis_d;
  logic             done_q, done_d;

  logic at_end;
  logic bad_next;
  logic bp_hit;
  logic restart;

  assign at_end   = (pc_q == end_addr);
  assign bad_next = (next_addr[1:0] != 2'b00);
  assign restart  = (state_q == StHalt) && start;

`ifdef PC_BREAKPOINT_EN
  logic resume_q, resume_d;
  // The resume flag lets the instruction at the breakpoint run once after stopping on it.
  assign bp_hit = (state_q == StRun) && bp_valid && (pc_q == bp_addr) && !resume_q;
`else
  assign bp_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (halt_req)   state_d = StHalt;
        else if (start) state_d = StRun;
        else if (step)  state_d = StStep;
      end
      StRun, StStep: begin
        if (at_end)                    state_d = StHalt;
        else if (bp_hit)               state_d = StIdle;
        else if (bad_next || halt_req) state_d = StHalt;
        else if (state_q == StStep)    state_d = StIdle;
      end
      StHalt: begin
        if (start) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from registered state and pc
  always_comb begin
    busy    = (state_q == StRun) || (state_q == StStep);
    exec_en = busy && !at_end && !bp_hit;
  end

  always_comb begin
    pc_d      = pc_q;
    retired_d = retired_q;
    mis_d     = mis_q;
`ifdef PC_BREAKPOINT_EN
    resume_d  = resume_q;
`endif
    if (restart) begin
      pc_d      = RESET_ADDR;
      retired_d = '0;
      mis_d     = 1'b0;
`ifdef PC_BREAKPOINT_EN
      resume_d  = 1'b0;
`endif
    end else if (exec_en) begin
      // A misaligned target still counts as committed; pc stays on the offending instruction.
      retired_d = retired_q + CNT_W'(1);
      if (bad_next) mis_d = 1'b1;
      else          pc_d  = next_addr;
`ifdef PC_BREAKPOINT_EN
      resume_d  = 1'b0;
    end else if (bp_hit) begin
      resume_d  = 1'b1;
`endif
    end
    done_d = (state_d == StHalt) && (state_q != StHalt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_ADDR;
      retired_q <= '0;
      mis_q     <= 1'b0;
      done_q    <= 1'b0;
`ifdef PC_BREAKPOINT_EN
      resume_q  <= 1'b0;
`endif
    end else begin
      pc_q      <= pc_d;
      retired_q <= retired_d;
      mis_q     <= mis_d;
      done_q    <= done_d;
`ifdef PC_BREAKPOINT_EN
      resume_q  <= resume_d;
`endif
    end
  end

  assign pc         = pc_q;
  assign retired    = retired_q;
  assign misaligned = mis_q;
  assign done       = done_q;

endmodule
